multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Multi-cycle control unit for the CPU datapath.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives all datapath mux selects and write enables from the latched instruction.
- Adds a data-memory ready handshake with a timeout.
- Sits between the instruction register and the PC, register file, ALU and data memory.

Parameters:
- MEM_TIMEOUT, 15: max cycles spent in MEM waiting for mem_ready before abort; legal range 1..255.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Instr  in  32  instruction register output; opcode is Instr[31:26], func is Instr[3:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  data memory has completed the current read or write.
- instr_lden  out  1  load the instruction register.
- pc_lden  out  1  load the PC.
- pc_sel  out  1  0 selects PC+4, 1 selects PC+4+offset.
- rf_b_sel  out  1  0 selects rt, 1 selects rd.
- alu_rf_a_sel  out  1  0 selects RF_A, 1 selects constant 0.
- alu_bin_sel  out  1  0 selects RF_B, 1 selects Immed.
- alu_func  out  4  ALU operation.
- rf_wrdata_sel  out  1  1 selects ALU_out, 0 selects MEM_out.
- rf_wren  out  1  register file write enable.
- mem_rden  out  1  data memory read request.
- mem_wren  out  1  data memory write request.
- byte_op  out  1  byte access (lb/sb).
- illegal_op  out  1  one-cycle pulse: unknown opcode was skipped.
- mem_err  out  1  one-cycle pulse: memory timeout abort.
- state  out  3  current state, for debug.

Behaviour:
- States and encodings: INIT=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, BRANCH=6.
- Reset: state=INIT, timeout counter=0, all outputs 0, including pulses and alu_func.
- Outputs are Moore-style, decoded from the state register and Instr. Only state and the counter are flopped.
- Default for every output in every state is 0.
- INIT: one cycle, all outputs 0, then FETCH.
- FETCH: instr_lden=1, then DECODE.
- DECODE: all-zero Instr is a NOP.
  - NOP: pc_lden=1, go to FETCH.
  - b (111111): pc_sel=1, pc_lden=1, go to FETCH.
  - beq (000000, non-zero word) and bne (000001): go to BRANCH.
  - ALU (100000), li (111000), lui (111001), addi (110000), andi (110010), ori (110011), lb (000011), lw (001111), sb (000111), sw (011111): go to EXEC.
  - Any other opcode: illegal_op=1, pc_lden=1, go to FETCH.
- EXEC and following cycles hold the same selects for the current opcode:
  - ALU: alu_func=func, rf_b_sel=0, bin=0, a_sel=0.
  - li/lui: a_sel=1, bin=1, func=0000, rf_b_sel=1.
  - addi: a_sel=0, bin=1, func=0000.
  - andi: a_sel=0, bin=1, func=0010.
  - ori: a_sel=0, bin=1, func=0011.
  - Memory ops: a_sel=0 (base register), bin=1, func=0000, rf_b_sel=1.
  - Next state: MEM for memory ops, WB otherwise.
- MEM:
  - Assert mem_rden (lb/lw) or mem_wren (sb/sw) continuously; byte_op=1 for lb/sb.
  - Counter increments each MEM cycle.
  - mem_ready in the same cycle is legal (zero-wait).
  - On mem_ready: loads go to WB; stores assert pc_lden=1 and go to FETCH. Counter clears.
  - If counter reaches MEM_TIMEOUT without mem_ready: mem_err=1, pc_lden=1, drop requests, go to FETCH, counter clears.
  - Any mem_ready arriving after an abort is ignored.
- WB:
  - rf_wren=1, pc_lden=1, then FETCH.
  - rf_wrdata_sel=0 for loads, 1 otherwise.
  - Stores never assert rf_wren.
- BRANCH:
  - rf_b_sel=1, bin=0, a_sel=0, func=0001.
  - pc_sel=zero (beq) or ~zero (bne); pc_lden=1; then FETCH.
- pc_lden is asserted exactly once per instruction; rf_wren at most once.
- Reset asserted mid-instruction: outputs go to 0 immediately (async); the instruction is abandoned.
- Cycle counts, FETCH to next FETCH: NOP/b/illegal 2; branch 3; ALU/imm 4; store 4+w; load 5+w, where w = cycles waited for mem_ready.

Optional Feature:
- Macro: MCTRL_INSTR_CNT_EN.
- When defined, adds output port instr_retired (out, 32 bits).
  - Reset to 0.
  - Increments by 1 on every clock edge where pc_lden=1 and mem_err=0 and illegal_op=0.
  - Wraps from 0xFFFFFFFF to 0.
- When undefined, the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then Instr=0x00000000 held: state sequence 0,1,2,1,2…; pc_lden high in each DECODE; rf_wren and mem_* never high.
- Instr=ALU add (opcode 100000, func 0000): states 1,2,3,5; in WB rf_wren=1, rf_wrdata_sel=1, alu_func=0000, rf_b_sel=0; exactly one pc_lden pulse.
- beq with zero=1, then zero=0: BRANCH gives pc_sel=1 then 0, alu_func=0001. bne with zero=0 gives pc_sel=1.
- lw with mem_ready arriving on the 3rd MEM cycle: mem_rden high for 3 cycles, then WB with rf_wren=1 and rf_wrdata_sel=0. Same with sb: mem_wren high, byte_op=1, no rf_wren.
- sw with mem_ready held 0 and MEM_TIMEOUT=4: mem_wren high for 4 cycles, then mem_err pulse with pc_lden=1 and return to FETCH. A late mem_ready is ignored.
- Opcode 101010: illegal_op pulses in DECODE and pc_lden=1. Reset asserted during MEM drops mem_rden asynchronously and state goes to 0. With MCTRL_INSTR_CNT_EN, instr_retired counts only the legal instructions.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: bundle between the multi-cycle control unit and its datapath.
//   Instr, zero, mem_ready : datapath -> controller (instruction word, ALU zero flag,
//                            data memory completion)
//   instr_lden .. state    : controller -> datapath (mux selects, write enables,
//                            memory requests, error pulses, debug state)
//   instr_retired          : retired-instruction counter, present only when
//                            MCTRL_INSTR_CNT_EN is defined
// Modports: master = controller side, slave = datapath side.
interface multicycle_ctrl_if;
  logic [31:0] Instr;
  logic        zero;
  logic        mem_ready;
  logic        instr_lden;
  logic        pc_lden;
  logic        pc_sel;
  logic        rf_b_sel;
  logic        alu_rf_a_sel;
  logic        alu_bin_sel;
  logic [3:0]  alu_func;
  logic        rf_wrdata_sel;
  logic        rf_wren;
  logic        mem_rden;
  logic        mem_wren;
  logic        byte_op;
  logic        illegal_op;
  logic        mem_err;
  logic [2:0]  state;
`ifdef MCTRL_INSTR_CNT_EN
  logic [31:0] instr_retired;

  modport master (
    input  Instr, zero, mem_ready,
    output instr_lden, pc_lden, pc_sel, rf_b_sel, alu_rf_a_sel, alu_bin_sel,
           alu_func, rf_wrdata_sel, rf_wren, mem_rden, mem_wren, byte_op,
           illegal_op, mem_err, state, instr_retired
  );

  modport slave (
    output Instr, zero, mem_ready,
    input  instr_lden, pc_lden, pc_sel, rf_b_sel, alu_rf_a_sel, alu_bin_sel,
           alu_func, rf_wrdata_sel, rf_wren, mem_rden, mem_wren, byte_op,
           illegal_op, mem_err, state, instr_retired
  );
`else
  modport master (
    input  Instr, zero, mem_ready,
    output instr_lden, pc_lden, pc_sel, rf_b_sel, alu_rf_a_sel, alu_bin_sel,
           alu_func, rf_wrdata_sel, rf_wren, mem_rden, mem_wren, byte_op,
           illegal_op, mem_err, state
  );

  modport slave (
    output Instr, zero, mem_ready,
    input  instr_lden, pc_lden, pc_sel, rf_b_sel, alu_rf_a_sel, alu_bin_sel,
           alu_func, rf_wrdata_sel, rf_wren, mem_rden, mem_wren, byte_op,
           illegal_op, mem_err, state
  );
`endif
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle CPU control unit. Walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB (or BRANCH) and decodes every datapath select and
// write enable from the state register and the latched instruction (Moore style;
// only the state and the MEM wait counter are flopped).
// Ports:
//   Clk   - system clock, rising edge
//   Reset - asynchronous active-high reset
//   bus   - multicycle_ctrl_if.master (instruction/flags in, controls out)
// Parameter MEM_TIMEOUT (1..255): MEM cycles allowed before the access is aborted.
// Optional macro MCTRL_INSTR_CNT_EN adds a 32-bit retired-instruction counter.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic              Clk,
  input  logic              Reset,
  multicycle_ctrl_if.master bus
);

  localparam int unsigned CNT_W = 8;

  localparam logic [5:0] OP_BEQ  = 6'b000000;
  localparam logic [5:0] OP_BNE  = 6'b000001;
  localparam logic [5:0] OP_B    = 6'b111111;
  localparam logic [5:0] OP_ALU  = 6'b100000;
  localparam logic [5:0] OP_LI   = 6'b111000;
  localparam logic [5:0] OP_LUI  = 6'b111001;
  localparam logic [5:0] OP_ADDI = 6'b110000;
  localparam logic [5:0] OP_ANDI = 6'b110010;
  localparam logic [5:0] OP_ORI  = 6'b110011;
  localparam logic [5:0] OP_LB   = 6'b000011;
  localparam logic [5:0] OP_LW   = 6'b001111;
  localparam logic [5:0] OP_SB   = 6'b000111;
  localparam logic [5:0] OP_SW   = 6'b011111;

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_BRANCH = 3'd6
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic [5:0] w_op;
  logic [3:0] w_func;
  logic       w_is_load;
  logic       w_is_store;
  logic       w_is_byte;
  logic       w_is_exec_op;
  logic       w_unused_instr;

  logic       w_instr_lden;
  logic       w_pc_lden;
  logic       w_pc_sel;
  logic       w_rf_b_sel;
  logic       w_alu_rf_a_sel;
  logic       w_alu_bin_sel;
  logic [3:0] w_alu_func;
  logic       w_rf_wrdata_sel;
  logic       w_rf_wren;
  logic       w_mem_rden;
  logic       w_mem_wren;
  logic       w_byte_op;
  logic       w_illegal_op;
  logic       w_mem_err;

  // Instruction field decode
  assign w_op           = bus.Instr[31:26];
  assign w_func         = bus.Instr[3:0];
  assign w_unused_instr = ^bus.Instr[25:4];
  assign w_is_load      = (w_op == OP_LB) || (w_op == OP_LW);
  assign w_is_store     = (w_op == OP_SB) || (w_op == OP_SW);
  assign w_is_byte      = (w_op == OP_LB) || (w_op == OP_SB);
  assign w_is_exec_op   = (w_op == OP_ALU)  || (w_op == OP_LI)   || (w_op == OP_LUI) ||
                          (w_op == OP_ADDI) || (w_op == OP_ANDI) || (w_op == OP_ORI) ||
                          w_is_load || w_is_store;

  // State and MEM wait counter
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state and Moore output decode
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_instr_lden    = 1'b0;
    w_pc_lden       = 1'b0;
    w_pc_sel        = 1'b0;
    w_rf_b_sel      = 1'b0;
    w_alu_rf_a_sel  = 1'b0;
    w_alu_bin_sel   = 1'b0;
    w_alu_func      = 4'b0000;
    w_rf_wrdata_sel = 1'b0;
    w_rf_wren       = 1'b0;
    w_mem_rden      = 1'b0;
    w_mem_wren      = 1'b0;
    w_byte_op       = 1'b0;
    w_illegal_op    = 1'b0;
    w_mem_err       = 1'b0;

    // EXEC, MEM and WB all hold the datapath selects of the current opcode
    if ((r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB)) begin
      case (w_op)
        OP_ALU:         w_alu_func = w_func;
        OP_LI, OP_LUI: begin
          w_alu_rf_a_sel = 1'b1;
          w_alu_bin_sel  = 1'b1;
          w_rf_b_sel     = 1'b1;
        end
        OP_ADDI:        w_alu_bin_sel = 1'b1;
        OP_ANDI: begin
          w_alu_bin_sel = 1'b1;
          w_alu_func    = 4'b0010;
        end
        OP_ORI: begin
          w_alu_bin_sel = 1'b1;
          w_alu_func    = 4'b0011;
        end
        OP_LB, OP_LW, OP_SB, OP_SW: begin
          w_alu_bin_sel = 1'b1;
          w_rf_b_sel    = 1'b1;
        end
        default: ;
      endcase
    end

    case (r_state)
      S_INIT:  w_state_nxt = S_FETCH;
      S_FETCH: begin
        w_instr_lden = 1'b1;
        w_state_nxt  = S_DECODE;
      end
      S_DECODE: begin
        if (bus.Instr == 32'h0) begin
          w_pc_lden   = 1'b1;
          w_state_nxt = S_FETCH;
        end else if (w_op == OP_B) begin
          w_pc_sel    = 1'b1;
          w_pc_lden   = 1'b1;
          w_state_nxt = S_FETCH;
        end else if ((w_op == OP_BEQ) || (w_op == OP_BNE)) begin
          w_state_nxt = S_BRANCH;
        end else if (w_is_exec_op) begin
          w_state_nxt = S_EXEC;
        end else begin
          w_illegal_op = 1'b1;
          w_pc_lden    = 1'b1;
          w_state_nxt  = S_FETCH;
        end
      end
      S_EXEC:  w_state_nxt = (w_is_load || w_is_store) ? S_MEM : S_WB;
      S_MEM: begin
        // Abort takes priority: requests are already dropped, so a ready here is moot
        if (r_cnt == CNT_W'(MEM_TIMEOUT)) begin
          w_mem_err   = 1'b1;
          w_pc_lden   = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_FETCH;
        end else begin
          w_mem_rden = w_is_load;
          w_mem_wren = w_is_store;
          w_byte_op  = w_is_byte;
          w_cnt_nxt  = r_cnt + CNT_W'(1);
          if (bus.mem_ready) begin
            w_cnt_nxt = '0;
            if (w_is_load) begin
              w_state_nxt = S_WB;
            end else begin
              w_pc_lden   = 1'b1;
              w_state_nxt = S_FETCH;
            end
          end
        end
      end
      S_WB: begin
        w_rf_wren       = 1'b1;
        w_pc_lden       = 1'b1;
        w_rf_wrdata_sel = ~w_is_load;
        w_state_nxt     = S_FETCH;
      end
      S_BRANCH: begin
        w_rf_b_sel  = 1'b1;
        w_alu_func  = 4'b0001;
        w_pc_sel    = (w_op == OP_BEQ) ? bus.zero : ~bus.zero;
        w_pc_lden   = 1'b1;
        w_state_nxt = S_FETCH;
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

  assign bus.instr_lden    = w_instr_lden;
  assign bus.pc_lden       = w_pc_lden;
  assign bus.pc_sel        = w_pc_sel;
  assign bus.rf_b_sel      = w_rf_b_sel;
  assign bus.alu_rf_a_sel  = w_alu_rf_a_sel;
  assign bus.alu_bin_sel   = w_alu_bin_sel;
  assign bus.alu_func      = w_alu_func;
  assign bus.rf_wrdata_sel = w_rf_wrdata_sel;
  assign bus.rf_wren       = w_rf_wren;
  assign bus.mem_rden      = w_mem_rden;
  assign bus.mem_wren      = w_mem_wren;
  assign bus.byte_op       = w_byte_op;
  assign bus.illegal_op    = w_illegal_op;
  assign bus.mem_err       = w_mem_err;
  assign bus.state         = 3'(r_state);

`ifdef MCTRL_INSTR_CNT_EN
  logic [31:0] r_instr_retired;

  // Counts instructions that completed normally (no abort, no illegal skip)
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_instr_retired <= '0;
    end else if (w_pc_lden && !w_mem_err && !w_illegal_op) begin
      r_instr_retired <= r_instr_retired + 32'd1;
    end
  end

  assign bus.instr_retired = r_instr_retired;
`endif

endmodule
